// File: rtl/bram_fifo_pkg.sv
// Shared constants for the block-RAM FIFO controller and its output buffer.
package bram_fifo_pkg;

  localparam int DATA_W_DEF = 36;               // RAM word width
  localparam int ADDR_W_DEF = 10;               // RAM address width
  localparam int DEPTH      = 1 << ADDR_W_DEF;  // RAM words
  localparam int OB_DEPTH   = 2;                // prefetch buffer entries
  localparam int COUNT_W    = ADDR_W_DEF + 2;   // holds 0..DEPTH+OB_DEPTH

  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/bram_fifo_outbuf.sv
// Small output queue fed by RAM read data; presents the head word on a
// valid/ready stream. The parent only pushes when it has reserved room.
module bram_fifo_outbuf
  import bram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  localparam int PTR_W = $clog2(OB_DEPTH);

  logic [DATA_W-1:0] mem_q [OB_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              pop_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[head_q];
  assign count_o = count_q;

  // Next pointers and occupancy; push and pop may coincide.
  always_comb begin
    head_d  = head_q + PTR_W'(pop_ok);
    tail_d  = tail_q + PTR_W'(push_i);
    count_d = count_q;
    case ({push_i, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // One storage register per entry, written when the tail points at it.
  for (genvar gi = 0; gi < OB_DEPTH; gi++) begin : g_entry
    // Capture incoming RAM data into this slot; cleared so m_data resets to 0.
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_q[gi] <= '0;
      end else if (push_i && (tail_q == PTR_W'(gi))) begin
        mem_q[gi] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller in front of a simple-dual-port block RAM. Writes go to
// port A, reads are prefetched through port B into a 2-entry output buffer.
// Reads win over writes so the RAM never sees both ports active together.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W+1:0] count,
  output logic              full,
  output logic              empty,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_count_q, ram_count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W+1:0] count_q, count_d;
  logic [1:0]        ob_count;
  logic [2:0]        credit_used;
  logic              rd_req;
  logic              out_hs;

  // Words already committed to the output side; a pop this cycle is not
  // counted so the read decision depends only on registered state.
  assign credit_used = {1'b0, ob_count} + {2'b00, inflight_q};

  assign full    = (ram_count_q == {1'b1, {ADDR_W{1'b0}}});
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_req  = !rst && (ram_count_q != '0) && (credit_used < 3'(OB_DEPTH));
  assign ram_ren   = rd_req;
  assign ram_raddr = rd_ptr_q;
  assign s_ready   = !rst && !full && !rd_req;
  assign ram_wen   = s_valid && s_ready;
  assign ram_waddr = wr_ptr_q;
  assign ram_wdata = s_data;
  assign out_hs    = m_valid && m_ready;

  // Next-state for pointers, RAM occupancy, in-flight flag and total count.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + ADDR_W'(ram_wen);
    rd_ptr_d    = rd_ptr_q + ADDR_W'(ram_ren);
    inflight_d  = ram_ren;
    ram_count_d = ram_count_q;
    if (ram_wen) begin
      ram_count_d = ram_count_q + 1'b1;
    end else if (ram_ren) begin
      ram_count_d = ram_count_q - 1'b1;
    end
    count_d = count_q;
    case ({ram_wen, out_hs})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; clearing inflight drops any read pending at reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
    end
  end

  bram_fifo_outbuf #(
    .DATA_W(DATA_W)
  ) u_outbuf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_data_i(ram_rdata),
    .pop_i      (m_ready),
    .valid_o    (m_valid),
    .data_o     (m_data),
    .count_o    (ob_count)
  );

endmodule
